// File: rtl/pe_cell_if.sv
// Data and select bundle for one systolic PE cell.
// The master drives the cell inputs; the slave side is the cell itself.
interface pe_cell_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] icur;
  logic [DATA_WIDTH-1:0] ibias;
  logic [DATA_WIDTH-1:0] ileft;
  logic [DATA_WIDTH-1:0] iright;
  logic [DATA_WIDTH-1:0] infifo;
  logic [DATA_WIDTH-1:0] ocur;
  logic [DATA_WIDTH-1:0] opfifo;
  logic [DATA_WIDTH-1:0] oright;
  logic [DATA_WIDTH-1:0] oleft;
  logic [DATA_WIDTH-1:0] onfifo;
  logic                  sel0;
  logic                  sel1;
  logic                  sel2;
  logic                  sel3;
  logic                  sel4;
  logic                  sel5;

  modport master (
    output icur, ibias, ileft, iright, infifo,
    output sel0, sel1, sel2, sel3, sel4, sel5,
    input  ocur, opfifo, oright, oleft, onfifo
  );

  modport slave (
    input  icur, ibias, ileft, iright, infifo,
    input  sel0, sel1, sel2, sel3, sel4, sel5,
    output ocur, opfifo, oright, oleft, onfifo
  );
endinterface

// File: rtl/pe_cell.sv
// One processing element of a linear systolic array: registers a saturated
// 3-point neighbourhood sum plus bias and forwards its own sample to neighbours.
module pe_cell #(
  parameter int DATA_WIDTH = 16
) (
  input logic     clk,
  input logic     rst,
  pe_cell_if.slave bus
);
  localparam int SW = DATA_WIDTH + 2;

  logic [DATA_WIDTH-1:0] ocur_q, ocur_d;
  logic [DATA_WIDTH-1:0] opfifo_q, opfifo_d;
  logic [DATA_WIDTH-1:0] oright_q, oright_d;
  logic [DATA_WIDTH-1:0] oleft_q, oleft_d;
  logic [DATA_WIDTH-1:0] onfifo_q, onfifo_d;

  logic [DATA_WIDTH-1:0] leftOp;
  logic [DATA_WIDTH-1:0] rightOp;
  logic [SW-1:0]         sumWide;
  logic [DATA_WIDTH-1:0] sumSat;

  function automatic logic [SW-1:0] sext(input logic [DATA_WIDTH-1:0] v);
    return {{2{v[DATA_WIDTH-1]}}, v};
  endfunction

  // Four DATA_WIDTH operands always fit in DATA_WIDTH+2 bits, so overflow of
  // the narrow result shows up as the top three bits disagreeing.
  always_comb begin
    leftOp  = bus.sel2 ? bus.infifo : bus.ileft;
    rightOp = bus.sel5 ? '0 : bus.iright;
    sumWide = sext(leftOp) + sext(bus.icur) + sext(rightOp) + sext(bus.ibias);
    sumSat  = sumWide[DATA_WIDTH-1:0];
    if (!sumWide[SW-1] && (sumWide[SW-2:DATA_WIDTH-1] != 2'b00)) begin
      sumSat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (sumWide[SW-1] && (sumWide[SW-2:DATA_WIDTH-1] != 2'b11)) begin
      sumSat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end

  always_comb begin
    ocur_d   = ocur_q;
    opfifo_d = '0;
    oright_d = bus.icur;
    oleft_d  = bus.icur;
    onfifo_d = bus.sel3 ? bus.icur : '0;
    if (bus.sel0) begin
      ocur_d = sumSat;
    end
    if (bus.sel1) begin
      opfifo_d = bus.sel0 ? sumSat : opfifo_q;
    end
    if (bus.sel4) begin
      oleft_d = bus.sel0 ? sumSat : ocur_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ocur_q   <= '0;
      opfifo_q <= '0;
      oright_q <= '0;
      oleft_q  <= '0;
      onfifo_q <= '0;
    end else begin
      ocur_q   <= ocur_d;
      opfifo_q <= opfifo_d;
      oright_q <= oright_d;
      oleft_q  <= oleft_d;
      onfifo_q <= onfifo_d;
    end
  end

  assign bus.ocur   = ocur_q;
  assign bus.opfifo = opfifo_q;
  assign bus.oright = oright_q;
  assign bus.oleft  = oleft_q;
  assign bus.onfifo = onfifo_q;
endmodule

// File: tb/tb_pe_cell.sv
// Directed-vector bench for pe_cell with hand-computed expected values.
module tb_pe_cell;
  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;

  pe_cell_if #(.DATA_WIDTH(16)) bus ();

  pe_cell #(.DATA_WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed output against its expected value.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs (sel bit i -> seli) and step past the next edge.
  task automatic applyStimulus(input logic [5:0] sel, input logic [15:0] cur,
                               input logic [15:0] bias, input logic [15:0] left,
                               input logic [15:0] right, input logic [15:0] fifo);
    bus.sel0   = sel[0];
    bus.sel1   = sel[1];
    bus.sel2   = sel[2];
    bus.sel3   = sel[3];
    bus.sel4   = sel[4];
    bus.sel5   = sel[5];
    bus.icur   = cur;
    bus.ibias  = bias;
    bus.ileft  = left;
    bus.iright = right;
    bus.infifo = fifo;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".ocur"},   bus.ocur,   16'h0000);
    checkOutput({tag, ".opfifo"}, bus.opfifo, 16'h0000);
    checkOutput({tag, ".oright"}, bus.oright, 16'h0000);
    checkOutput({tag, ".oleft"},  bus.oleft,  16'h0000);
    checkOutput({tag, ".onfifo"}, bus.onfifo, 16'h0000);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;

    // Reset with random data and selects.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(6'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    16'($urandom), 16'($urandom));
    end
    checkAllZero("reset");

    // First compute: 2 + 5 + 3 + 1 = 11.
    rst = 1'b0;
    applyStimulus(6'b000001, 16'd5, 16'd1, 16'd2, 16'd3, 16'd0);
    checkOutput("basic.ocur",   bus.ocur,   16'd11);
    checkOutput("basic.oright", bus.oright, 16'd5);
    checkOutput("basic.oleft",  bus.oleft,  16'd5);
    checkOutput("basic.opfifo", bus.opfifo, 16'd0);
    checkOutput("basic.onfifo", bus.onfifo, 16'd0);

    // Load opfifo, then hold with sel0=0 while data changes.
    applyStimulus(6'b000011, 16'd5, 16'd1, 16'd2, 16'd3, 16'd0);
    checkOutput("load.opfifo", bus.opfifo, 16'd11);
    applyStimulus(6'b000010, 16'd20, 16'd50, 16'd30, 16'd40, 16'd60);
    checkOutput("hold.ocur",   bus.ocur,   16'd11);
    checkOutput("hold.opfifo", bus.opfifo, 16'd11);
    checkOutput("hold.oright", bus.oright, 16'd20);
    checkOutput("hold.oleft",  bus.oleft,  16'd20);
    applyStimulus(6'b010000, 16'd21, 16'd50, 16'd30, 16'd40, 16'd60);
    checkOutput("holdL.oleft",  bus.oleft,  16'd11);
    checkOutput("holdL.oright", bus.oright, 16'd21);
    checkOutput("holdL.opfifo", bus.opfifo, 16'd0);

    // Left-edge halo and right zero padding: 100 + 10 + 0 + 0.
    applyStimulus(6'b100101, 16'd10, 16'd0, 16'd7, 16'd9, 16'd100);
    checkOutput("edge.ocur", bus.ocur, 16'd110);

    // Saturation and signed boundaries.
    applyStimulus(6'b000001, 16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h0);
    checkOutput("satPos.ocur", bus.ocur, 16'h7FFF);
    applyStimulus(6'b000001, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h0);
    checkOutput("satNeg.ocur", bus.ocur, 16'h8000);
    applyStimulus(6'b000001, 16'hFFFD, 16'h0000, 16'h0001, 16'h0001, 16'h0);
    checkOutput("minus1.ocur", bus.ocur, 16'hFFFF);
    applyStimulus(6'b000001, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0);
    checkOutput("exactMax.ocur", bus.ocur, 16'h7FFF);
    applyStimulus(6'b000001, 16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 16'h0);
    checkOutput("maxPlus1.ocur", bus.ocur, 16'h7FFF);
    applyStimulus(6'b000001, 16'h8000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0);
    checkOutput("minMinus1.ocur", bus.ocur, 16'h8000);
    applyStimulus(6'b000001, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0);
    checkOutput("allMax.ocur", bus.ocur, 16'h7FFF);
    applyStimulus(6'b000001, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0);
    checkOutput("allMin.ocur", bus.ocur, 16'h8000);

    // Right-edge configuration: 6 + 4 + 0 + 2 = 12.
    applyStimulus(6'b101011, 16'd4, 16'd2, 16'd6, 16'd50, 16'd0);
    checkOutput("redge.ocur",   bus.ocur,   16'd12);
    checkOutput("redge.opfifo", bus.opfifo, 16'd12);
    checkOutput("redge.onfifo", bus.onfifo, 16'd4);
    applyStimulus(6'b100011, 16'd4, 16'd2, 16'd6, 16'd50, 16'd0);
    checkOutput("redgeOff.onfifo", bus.onfifo, 16'd0);
    checkOutput("redgeOff.opfifo", bus.opfifo, 16'd12);
    applyStimulus(6'b100001, 16'd4, 16'd2, 16'd6, 16'd50, 16'd0);
    checkOutput("pfifoOff.opfifo", bus.opfifo, 16'd0);

    // Stream: sum equals icur, so oleft/oright trail icur by one cycle.
    for (int k = 1; k <= 8; k++) begin
      logic [5:0] sel;
      sel = (k <= 4) ? 6'b000001 : 6'b010001;
      applyStimulus(sel, 16'(k), 16'd0, 16'd0, 16'd0, 16'd0);
      checkOutput($sformatf("stream%0d.oright", k), bus.oright, 16'(k));
      checkOutput($sformatf("stream%0d.oleft", k),  bus.oleft,  16'(k));
      checkOutput($sformatf("stream%0d.ocur", k),   bus.ocur,   16'(k));
    end

    // Reset wins over every select being active.
    rst = 1'b1;
    applyStimulus(6'b111111, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9);
    checkAllZero("rstPrio");
    rst = 1'b0;
    applyStimulus(6'b000001, 16'd1, 16'd1, 16'd1, 16'd1, 16'd0);
    checkOutput("afterRst.ocur", bus.ocur, 16'd4);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule

// File: doc/pe_cell.md
Name: pe_cell

Overview:
- One processing element of a linear systolic PE array (8 cells per row in the parent array).
- Each cycle it registers a 3-point neighbourhood sum plus bias: left operand + own sample + right operand + bias.
- It forwards its own sample to both neighbours.
- Static select bits configure it as an interior cell, a left-edge cell (takes halo data from a FIFO) or a right-edge cell (drives FIFO and next-tile outputs).

Parameters:
- DATA_WIDTH, 16, width of every data port; two's-complement signed.

Ports:
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  reset, synchronous, active-high
- icur  input  DATA_WIDTH  own input sample this cycle
- ibias  input  DATA_WIDTH  bias term added to the sum
- ileft  input  DATA_WIDTH  sample from left neighbour (its oright)
- iright  input  DATA_WIDTH  sample from right neighbour (its oleft)
- infifo  input  DATA_WIDTH  halo sample from previous-tile FIFO
- ocur  output  DATA_WIDTH  registered result
- opfifo  output  DATA_WIDTH  registered result copy to next-tile path
- oright  output  DATA_WIDTH  registered own sample toward right neighbour
- oleft  output  DATA_WIDTH  registered value toward left neighbour
- onfifo  output  DATA_WIDTH  registered own sample toward FIFO
- sel0  input  1  compute enable
- sel1  input  1  opfifo enable
- sel2  input  1  left operand select: 0 = ileft, 1 = infifo
- sel3  input  1  onfifo enable
- sel4  input  1  oleft source: 0 = own sample, 1 = result
- sel5  input  1  right operand select: 0 = iright, 1 = zero padding

Behaviour:
- All outputs are registers, updated on the rising edge of clk. No combinational input-to-output path.
- Reset (rst=1 at a clock edge) clears ocur, opfifo, oright, oleft and onfifo to 0. Reset has priority over every select. Outputs are 0 from the first edge after rst rises; normal operation resumes on the edge after rst falls.
- Operand selection:
  - L = sel2 ? infifo : ileft
  - R = sel5 ? 0 : iright
- Sum: S = L + icur + R + ibias.
  - Evaluated at DATA_WIDTH+2 bits, sign-extended.
  - Saturated to the DATA_WIDTH signed range: above 2^(DATA_WIDTH-1)-1 clamps to max (0x7FFF at default); below -2^(DATA_WIDTH-1) clamps to min (0x8000).
- Compute path (sel0):
  - sel0=1: ocur <= saturated S.
  - sel0=0: ocur holds its value.
- opfifo:
  - sel1=1 and sel0=1: opfifo <= saturated S.
  - sel1=1 and sel0=0: opfifo holds.
  - sel1=0: opfifo <= 0.
- oright <= icur every cycle, regardless of sel0.
- oleft:
  - sel4=0: oleft <= icur.
  - sel4=1: oleft <= saturated S when sel0=1, else the current ocur.
- onfifo: sel3=1 gives onfifo <= icur; sel3=0 gives onfifo <= 0.
- Latency:
  - Result: 1 cycle from icur/ibias/operands to ocur.
  - Neighbour data: reaches the adjacent cell's ileft/iright one cycle after it is presented. A cell's sum therefore combines its current sample with neighbours' previous-cycle samples.
- Select inputs are quasi-static but must be sampled each cycle. A change takes effect on the next edge, with no glitch or extra latency.
- No handshake: the cell accepts a new sample every cycle.
- Simultaneous rst=1 and sel0=1: reset wins; all outputs are 0.

Test Plan:
- Reset: drive random inputs with rst=1 for 2 cycles -> all five outputs 0; with rst=0, icur=5, ibias=1, ileft=2, iright=3, all sel 0 except sel0=1 -> next edge ocur=11, oright=5, oleft=5, opfifo=0, onfifo=0.
- Edge selects: sel2=1, infifo=100, ileft=7, sel5=1, iright=9, icur=10, ibias=0 -> ocur=110.
- Saturation: icur=0x7000, ileft=0x7000, iright=0, ibias=0 -> ocur=0x7FFF; icur=0x8000, ileft=0x8000 -> ocur=0x8000; icur=-3, ileft=1, iright=1, ibias=0 -> ocur=0xFFFF.
- Hold: compute with ocur=11, then sel0=0 and change all data inputs -> ocur stays 11; with sel1=1, opfifo also holds its last value; oright still tracks icur.
- Right-edge configuration: sel1=1, sel3=1, sel5=1, icur=4, ileft=6, ibias=2, iright=50 -> ocur=12, opfifo=12, onfifo=4; then sel3=0 -> onfifo=0 on the next edge.
- Stream and oleft source: icur sequence 1,2,3,… with sel4=0 -> oleft and oright trail icur by exactly one cycle; sel4=1 -> oleft equals ocur each cycle.
